ah_packet_converter_n2w_cdt: RTL

//  Parametrised narrow-to-wide packet converter with credit-based flow control on both sides.

---
 rtl/ah_pktconv_pkg.sv | 24 ++
 rtl/ah_packet_converter_n2w_cdt_fifo.sv | 68 ++++++
 rtl/ah_packet_converter_n2w_cdt.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ah_pktconv_pkg.sv
// Shared helpers for the narrow-to-wide packet converter: lane ratio,
// ceil-log2 and index-width functions used to size counters and pointers.
`timescale 1ns/1ps
package ah_pktconv_pkg;

    // Number of narrow beats packed into one wide word (ceil(out_w/in_w)).
    function automatic int ratio(input int in_w, input int out_w);
        return (out_w + in_w - 1) / in_w;
    endfunction

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Width of an index that addresses n entries, never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/ah_packet_converter_n2w_cdt_fifo.sv
// ah_credit_fifo: DEPTH x W synchronous FIFO with show-ahead read data.
// A pop in the same cycle as a push to a full FIFO frees the slot first,
// so that push is accepted; a push that finds no room raises overflow.
`timescale 1ns/1ps
module ah_credit_fifo
    import ah_pktconv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         overflow
);
    localparam int PTR_W = idx_w(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign rdata = mem[rd_ptr_q];

    // Accept/advance decisions and next pointer/occupancy values.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        overflow = push && !push_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is tracked by count_q, so stale entries are never read.
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ah_packet_converter_n2w_cdt.sv
// ah_packet_converter_n2w_cdt: packs RATIO narrow beats from a credit-fed
// input FIFO into one wide word, emitted only while a downstream credit is held.
// Optional feature macro AH_PKTCONV_FLUSH_EN adds wlast (early word close)
// and rkeep (filled-lane mask).
`timescale 1ns/1ps
module ah_packet_converter_n2w_cdt
    import ah_pktconv_pkg::*;
#(
    parameter int IN_W      = 10,
    parameter int OUT_W     = 15,
    parameter int IN_DEPTH  = 4,
    parameter int RCREDITS  = 2,
    parameter int LSB_FIRST = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_W-1:0]                 wdata,
    input  logic                            wvalid,
`ifdef AH_PKTCONV_FLUSH_EN
    input  logic                            wlast,
    output logic [ratio(IN_W, OUT_W)-1:0]   rkeep,
`endif
    output logic                            wcredit,
    output logic [OUT_W-1:0]                rdata,
    output logic                            rvalid,
    input  logic                            rcredit,
    output logic                            err
);
    localparam int RATIO  = ratio(IN_W, OUT_W);
    localparam int LANE_W = idx_w(RATIO);
    localparam int CRED_W = clog2(RCREDITS + 1);
    localparam int PAD    = RATIO * IN_W - OUT_W;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(RCREDITS);
`ifdef AH_PKTCONV_FLUSH_EN
    localparam int FW = IN_W + 1;
`else
    localparam int FW = IN_W;
`endif

    logic [FW-1:0]     fifo_din, fifo_dout;
    logic              fifo_full, fifo_empty, fifo_ovf;
    logic [IN_W-1:0]   head_beat;
    logic              closes, pop, emit, cred_ovf;
    logic [IN_W-1:0]   acc_q [RATIO];
    logic [IN_W-1:0]   lane_val [RATIO];
    logic [OUT_W-1:0]  word;
    logic [RATIO-1:0]  keep;

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [CRED_W-1:0] credit_cnt_q, credit_cnt_d;
    logic [OUT_W-1:0]  rdata_q, rdata_d;
    logic [RATIO-1:0]  rkeep_q, rkeep_d;
    logic              rvalid_q, rvalid_d, wcredit_q, wcredit_d, err_q, err_d;

`ifdef AH_PKTCONV_FLUSH_EN
    assign fifo_din = {wlast, wdata};
    assign closes   = (lane_q == LAST_LANE) || fifo_dout[IN_W];
    assign rkeep    = rkeep_q;
`else
    assign fifo_din = wdata;
    assign closes   = (lane_q == LAST_LANE);
`endif
    assign head_beat = fifo_dout[IN_W-1:0];

    ah_credit_fifo #(.DEPTH(IN_DEPTH), .W(FW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wvalid),
        .pop      (pop),
        .wdata    (fifo_din),
        .rdata    (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    // A word-closing beat is only popped while a credit is held.
    assign pop  = !fifo_empty && (!closes || (credit_cnt_q != '0));
    assign emit = pop && closes;

    // Assemble the outgoing word: filled lanes, the closing beat, zero above.
    always_comb begin
        word = '0;
        keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) < lane_q)       lane_val[i] = acc_q[i];
            else if (LANE_W'(i) == lane_q) lane_val[i] = head_beat;
            else                           lane_val[i] = '0;
            keep[i] = (LANE_W'(i) <= lane_q);
        end
        for (int b = 0; b < OUT_W; b++) begin
            if (LSB_FIRST != 0) word[b] = lane_val[b / IN_W][b % IN_W];
            else                word[b] = lane_val[RATIO - 1 - (b + PAD) / IN_W][(b + PAD) % IN_W];
        end
    end

    // Next-state for lane, credit counter, sticky error and output registers.
    always_comb begin
        lane_d       = lane_q;
        credit_cnt_d = credit_cnt_q;
        cred_ovf     = 1'b0;
        if (pop) lane_d = emit ? '0 : lane_q + 1'b1;
        case ({rcredit, emit})
            2'b10: begin
                if (credit_cnt_q == CRED_MAX) cred_ovf = 1'b1;
                else                          credit_cnt_d = credit_cnt_q + 1'b1;
            end
            2'b01:   credit_cnt_d = credit_cnt_q - 1'b1;
            default: credit_cnt_d = credit_cnt_q;
        endcase
        err_d     = err_q || fifo_ovf || cred_ovf;
        wcredit_d = pop;
        rvalid_d  = emit;
        rdata_d   = emit ? word : rdata_q;
        rkeep_d   = emit ? keep : rkeep_q;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q       <= '0;
            credit_cnt_q <= CRED_MAX;
            err_q        <= 1'b0;
            wcredit_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rkeep_q      <= '0;
        end else begin
            lane_q       <= lane_d;
            credit_cnt_q <= credit_cnt_d;
            err_q        <= err_d;
            wcredit_q    <= wcredit_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rkeep_q      <= rkeep_d;
        end
    end

    // Partial-word lane storage; lane_q alone marks which lanes are valid.
    always_ff @(posedge clk) begin
        if (pop && !closes) acc_q[lane_q] <= head_beat;
    end

    assign wcredit = wcredit_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign err     = err_q;

endmodule
